conv_encoder_tx: RTL and testbench
==================================

// Module: conv_encoder_tx
// PURPOSE
//  Rate-1/2, K=3 convolutional encoder: the transmit-side counterpart of the PipeViterbi decoder.
//  - Accepts N_BITS-bit data words over a valid/ready handshake.
//  - Emits 2*N_BITS-bit codewords in the same symbol packing the decoder's input shifter consumes.
//  - Encoder state carries across words within a frame.
//  - At frame end, appends one zero-data flush word so the trellis returns to state 0.
// PARAMETERS
//  N_BITS  8      data bits per input word; codeword width is 2*N_BITS
//  G0      3'b111 generator for the upper symbol bit (bit2 = current input, bit0 = oldest)
//  G1      3'b101 generator for the lower symbol bit
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  in_data    in   N_BITS    data word; in_data[N_BITS-1] is the first bit in time
//  in_valid   in   1         in_data/in_last valid
//  in_last    in   1         word is the last of its frame
//  in_ready   out  1         block accepts a word this cycle
//  out_code   out  2*N_BITS  codeword; [2N-1:2N-2] encodes the first bit, {g0,g1} with g0 in the MSB
//  out_valid  out  1         out_code valid
//  out_last   out  1         codeword is the flush word closing a frame
//  out_ready  in   1         downstream accepts out_code this cycle
// BEHAVIOUR
//  - Reset: out_code=0, out_valid=0, out_last=0, encoder state {s1,s2}=2'b00, FSM=ST_DATA.
//    in_ready=0 while rst is high.
//  - Per bit b, using s1 = previous bit and s2 = bit before that:
//    g0 = ^({b,s1,s2} & G0); g1 = ^({b,s1,s2} & G1); then s2<=s1, s1<=b.
//    All N_BITS bits are unrolled combinationally inside one cycle.
//  - Output register is one deep. slot_free = !out_valid | out_ready.
//  - ST_DATA:
//    - in_ready = slot_free.
//    - Transfer on in_valid & in_ready: out_code <= encode(in_data, state); out_valid <= 1; out_last <= 0.
//    - Encoder state advances to the last two bits of the word.
//    - If in_last was set, go to ST_FLUSH.
//  - ST_FLUSH:
//    - in_ready = 0.
//    - When slot_free: out_code <= encode(0, state); out_valid <= 1; out_last <= 1.
//    - State <= 2'b00; go to ST_DATA.
//  - Latency: the codeword is visible the cycle after acceptance. Full throughput of 1 word/cycle
//    holds when out_ready is held high; the flush costs one input bubble per frame.
//  - Output drop: out_valid falls when out_ready=1 and no new load occurs that cycle.
//  - Backpressure: while out_valid & !out_ready, out_code, out_valid and out_last hold stable,
//    and neither encoder state nor FSM changes.
//  - Simultaneous events:
//    - Load and drain in the same cycle: the load wins; out_valid stays 1.
//    - in_valid while in_ready=0: ignored; the upstream source must hold the word.
//  - A single-word frame (in_last on the first word) is legal: data codeword, then flush codeword.
//  - Reset mid-frame or mid-stall: the pending codeword is discarded and state clears.
//    No flush is emitted.
//  - No combinational path from out_ready to out_valid. in_ready depends combinationally on
//    out_ready and the FSM state only.
// STRUCTURE
//  - Shared package: K=3, default G0/G1, state encoding localparams ST_DATA/ST_FLUSH, and the
//    symbol-packing order. The Viterbi branch-metric logic uses the same package.
//  - One sub-module: conv_enc_core.
//    - Purely combinational; ports data, state_in, code, state_out.
//    - Instantiated once; the flush path drives data=0 through the same core.
//  - Top level: FSM, output register, handshake.
// TESTING
//  1. From reset, send in_data=8'h80 with in_last=0 -> out_code=16'hEC00 one cycle later
//     (impulse response: 11 10 11).
//  2. From reset, send 8'hFF with in_last=1 and out_ready held 1 -> 16'hDAAA, out_last=0, then
//     16'h7000, out_last=1. in_ready is low for exactly one cycle.
//  3. Send 8'h00 words from reset -> 16'h0000 each cycle at full throughput.
//     Encoder state stays 2'b00.
//  4. Hold out_ready=0 for 5 cycles with in_valid=1 -> codeword stable, in_ready=0, no words lost.
//     Release -> words drain in order.
//  5. Assert rst during ST_FLUSH with out_valid=1 -> out_valid=0 immediately.
//     Next 8'h80 gives 16'hEC00 (state cleared).
//  6. Loopback: random 64-word frames through conv_encoder_tx into PipeViterbi, error-free
//     channel -> decoded bytes equal source bytes.

Source files
------------

// File: rtl/conv_encoder_tx_pkg.sv
// Shared definitions for the rate-1/2 K=3 convolutional code (encoder and Viterbi branch metrics).
// Symbol packing: each input bit yields {g0,g1}, g0 in the MSB, first bit in time at the top of the word.
package conv_encoder_tx_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0_DEFAULT = 3'b111;
    localparam logic [K-1:0] G1_DEFAULT = 3'b101;

    typedef enum logic {
        ST_DATA  = 1'b0,
        ST_FLUSH = 1'b1
    } enc_fsm_t;

    function automatic logic [1:0] sym_pack(input logic g0, input logic g1);
        return {g0, g1};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational encoder: unrolls all N_BITS trellis steps in one cycle.
// state_in/state_out are {s1,s2}: s1 = most recent bit, s2 = the bit before it.
module conv_enc_core
    import conv_encoder_tx_pkg::*;
#(
    parameter int           N_BITS = 8,
    parameter logic [K-1:0] G0     = G0_DEFAULT,
    parameter logic [K-1:0] G1     = G1_DEFAULT
) (
    input  logic [N_BITS-1:0]   data,
    input  logic [1:0]          state_in,
    output logic [2*N_BITS-1:0] code,
    output logic [1:0]          state_out
);

    logic         s1;
    logic         s2;
    logic [K-1:0] win;

    always_comb begin
        s1   = state_in[1];
        s2   = state_in[0];
        win  = '0;
        code = '0;
        // MSB of data is the first bit in time, so walk downwards.
        for (int i = N_BITS - 1; i >= 0; i--) begin
            win             = {data[i], s1, s2};
            code[2*i +: 2]  = sym_pack(^(win & G0), ^(win & G1));
            s2              = s1;
            s1              = data[i];
        end
        state_out = {s1, s2};
    end

endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 encoder with one-deep output register; appends a zero flush word per frame.
// Codeword appears the cycle after acceptance; output holds while out_valid & !out_ready.
module conv_encoder_tx
    import conv_encoder_tx_pkg::*;
#(
    parameter int           N_BITS = 8,
    parameter logic [K-1:0] G0     = G0_DEFAULT,
    parameter logic [K-1:0] G1     = G1_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BITS-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [2*N_BITS-1:0] out_code,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
);

    enc_fsm_t              fsm;
    enc_fsm_t              fsm_nxt;
    logic [1:0]            enc_state;
    logic [1:0]            core_state;
    logic [N_BITS-1:0]     core_data;
    logic [2*N_BITS-1:0]   core_code;
    logic                  slot_free;
    logic                  accept;
    logic                  load;

    assign slot_free = !out_valid || out_ready;

    // Flush reuses the same core with a zero data word.
    assign core_data = (fsm == ST_FLUSH) ? '0 : in_data;

    conv_enc_core #(
        .N_BITS (N_BITS),
        .G0     (G0),
        .G1     (G1)
    ) u_core (
        .data      (core_data),
        .state_in  (enc_state),
        .code      (core_code),
        .state_out (core_state)
    );

    always_comb begin
        fsm_nxt  = fsm;
        in_ready = 1'b0;
        accept   = 1'b0;
        load     = 1'b0;
        case (fsm)
            ST_DATA: begin
                in_ready = slot_free && !rst;
                accept   = in_valid && in_ready;
                load     = accept;
                if (accept && in_last) begin
                    fsm_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                load = slot_free;
                if (slot_free) begin
                    fsm_nxt = ST_DATA;
                end
            end
            default: fsm_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= ST_DATA;
            enc_state <= 2'b00;
            out_code  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            fsm <= fsm_nxt;
            if (load) begin
                out_code  <= core_code;
                out_valid <= 1'b1;
                out_last  <= (fsm == ST_FLUSH);
                enc_state <= (fsm == ST_FLUSH) ? 2'b00 : core_state;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed table plus multi-cycle sequences and a random frame against a bit-serial reference.
module tb_conv_encoder_tx;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_code;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    int n_pass;
    int n_total;

    conv_encoder_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [15:0] exp_code;
        logic [15:0] exp_flush;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a word and returns 1ns after the edge on which it was taken.
    task automatic send_word(input logic [7:0] d, input logic l);
        int n;
        n        = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("send_timeout", 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] model_enc(input logic [7:0] d, input logic [1:0] st_in,
                                              output logic [1:0] st_out);
        logic [15:0] c;
        logic a, b, bit_in;
        a = st_in[1];
        b = st_in[0];
        c = '0;
        for (int i = 0; i < 8; i++) begin
            bit_in = d[7-i];
            c = {c[13:0], bit_in ^ a ^ b, bit_in ^ b};
            b = a;
            a = bit_in;
        end
        st_out = {a, b};
        return c;
    endfunction

    logic [15:0] exp_q[$];
    logic        exp_l[$];

    initial begin
        logic [7:0]  words[16];
        logic [1:0]  st;
        logic [15:0] c;
        logic [15:0] held;
        int          idx;
        int          got;

        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{8'h80, 1'b0, 16'hEC00, 16'h0000};
        vecs[1] = '{8'hFF, 1'b1, 16'hDAAA, 16'h7000};
        vecs[2] = '{8'h00, 1'b0, 16'h0000, 16'h0000};
        vecs[3] = '{8'h01, 1'b0, 16'h0003, 16'h0000};
        vecs[4] = '{8'h00, 1'b1, 16'hB000, 16'h0000};
        vecs[5] = '{8'hAA, 1'b0, 16'hE222, 16'h0000};
        vecs[6] = '{8'h0F, 1'b1, 16'hC0DA, 16'h7000};

        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_code",  {16'd0, out_code},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            send_word(vecs[i].data, vecs[i].last);
            chk("tbl_valid", {31'd0, out_valid}, 32'd1);
            chk("tbl_code",  {16'd0, out_code},  {16'd0, vecs[i].exp_code});
            chk("tbl_last",  {31'd0, out_last},  32'd0);
            if (vecs[i].last) begin
                chk("tbl_flush_in_ready", {31'd0, in_ready}, 32'd0);
                step();
                chk("tbl_flush_valid", {31'd0, out_valid}, 32'd1);
                chk("tbl_flush_code",  {16'd0, out_code},  {16'd0, vecs[i].exp_flush});
                chk("tbl_flush_last",  {31'd0, out_last},  32'd1);
                chk("tbl_post_flush_in_ready", {31'd0, in_ready}, 32'd1);
            end
        end
        step();
        chk("drop_valid", {31'd0, out_valid}, 32'd0);

        // Zero words at full throughput: ready every cycle, all-zero codewords.
        in_data  = 8'h00;
        in_last  = 1'b0;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("zero_in_ready", {31'd0, in_ready}, 32'd1);
            step();
            chk("zero_valid", {31'd0, out_valid}, 32'd1);
            chk("zero_code",  {16'd0, out_code},  32'd0);
        end
        in_valid = 1'b0;
        send_word(8'h80, 1'b0);
        chk("zero_then_impulse", {16'd0, out_code}, 32'h0000EC00);
        step();

        // Backpressure: codeword and ready must freeze, then the held word drains.
        out_ready = 1'b0;
        send_word(8'h80, 1'b0);
        held     = out_code;
        chk("bp_first", {16'd0, held}, 32'h0000EC00);
        in_data  = 8'hFF;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_code",     {16'd0, out_code}, {16'd0, held});
            chk("bp_valid",    {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_second", {16'd0, out_code}, 32'h0000DAAA);
        step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset while the flush word is pending behind a stall.
        out_ready = 1'b0;
        send_word(8'h0F, 1'b1);
        step();
        chk("flush_stall_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready},  32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        send_word(8'h80, 1'b0);
        chk("rst_mid_impulse", {16'd0, out_code}, 32'h0000EC00);
        chk("rst_mid_last",    {31'd0, out_last}, 32'd0);
        step();

        // Random 16-word frame under random backpressure vs. bit-serial reference.
        st = 2'b00;
        for (int i = 0; i < 16; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            c = model_enc(words[i], st, st);
            exp_q.push_back(c);
            exp_l.push_back(1'b0);
        end
        c = model_enc(8'h00, st, st);
        exp_q.push_back(c);
        exp_l.push_back(1'b1);
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 400 && got < 17; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (idx < 16);
            in_data   = (idx < 16) ? words[idx] : 8'h00;
            in_last   = (idx == 15);
            #1;
            if (out_valid && out_ready) begin
                chk("rand_code", {16'd0, out_code}, {16'd0, exp_q.pop_front()});
                chk("rand_last", {31'd0, out_last}, {31'd0, exp_l.pop_front()});
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("rand_count", got, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
